// File: rtl/muldiv_pkg.sv
// Shared types and op-decode helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } muldiv_state_e;

  function automatic logic is_div(input muldiv_op_e op);
    return op[2];
  endfunction

  function automatic logic is_signed_a(input muldiv_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_b(input muldiv_op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

  function automatic logic wants_high(input muldiv_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_MULHU};
  endfunction

  function automatic logic is_rem(input muldiv_op_e op);
    return op inside {OP_REM, OP_REMU};
  endfunction

endpackage

// File: rtl/muldiv_operand_prep.sv
// Combinational operand conditioning: magnitudes, result sign flags and the
// divide special-case detection, evaluated on the raw request operands.
module muldiv_operand_prep
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  muldiv_op_e      op,
  output logic [XLEN-1:0] abs_a,
  output logic [XLEN-1:0] abs_b,
  output logic            neg_result,
  output logic            neg_rem,
  output logic            div_by_zero,
  output logic            overflow
);

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  logic a_neg_s;
  logic b_neg_s;

  // Sign extraction and magnitude conversion; MIN_INT maps onto itself as an unsigned magnitude.
  always_comb begin
    a_neg_s     = is_signed_a(op) & a[XLEN-1];
    b_neg_s     = is_signed_b(op) & b[XLEN-1];
    abs_a       = a_neg_s ? -a : a;
    abs_b       = b_neg_s ? -b : b;
    neg_result  = a_neg_s ^ b_neg_s;
    neg_rem     = a_neg_s;
    div_by_zero = is_div(op) && (b == {XLEN{1'b0}});
    overflow    = ((op == OP_DIV) || (op == OP_REM)) && (a == MIN_INT) && (b == {XLEN{1'b1}});
  end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative radix-2 RV32M multiply/divide unit with valid/ready on both sides.
// Optional macro MULDIV_EARLY_OUT_EN: multiplies finish as soon as the remaining multiplier bits are zero.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN:0]     rem_q, rem_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  muldiv_op_e        op_q, op_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;

  muldiv_op_e        op_in_s;
  logic [XLEN-1:0]   abs_a_s, abs_b_s;
  logic              neg_result_s, neg_rem_s, div_by_zero_s, overflow_s;

  logic [XLEN:0]     mul_add_s;
  logic [2*XLEN-1:0] mul_step_s, mul_next_s;
  logic              mul_early_s;
  logic [XLEN+1:0]   rem_sh_s, diff_s;
  logic              qbit_s;
  logic [XLEN:0]     div_rem_s;
  logic [2*XLEN-1:0] div_acc_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quot_s, remv_s, fix_res_s;
`ifdef MULDIV_EARLY_OUT_EN
  logic [XLEN-1:0]   rest_mask_s;
`endif

  assign op_in_s = muldiv_op_e'(op);

  muldiv_operand_prep #(.XLEN(XLEN)) u_prep (
    .a           (a),
    .b           (b),
    .op          (op_in_s),
    .abs_a       (abs_a_s),
    .abs_b       (abs_b_s),
    .neg_result  (neg_result_s),
    .neg_rem     (neg_rem_s),
    .div_by_zero (div_by_zero_s),
    .overflow    (overflow_s)
  );

  // One datapath step: shift-add multiply, restoring divide, and final sign fix-up.
  always_comb begin
    // Multiply keeps {high product, unprocessed multiplier} in acc; carry rides into the top bit.
    mul_add_s  = acc_q[0] ? ({1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mcand_q})
                          : {1'b0, acc_q[2*XLEN-1:XLEN]};
    mul_step_s = {mul_add_s, acc_q[XLEN-1:1]};
`ifdef MULDIV_EARLY_OUT_EN
    rest_mask_s = ~({XLEN{1'b1}} << cnt_q);
    mul_early_s = ((mul_step_s[XLEN-1:0] & rest_mask_s) == {XLEN{1'b0}});
    mul_next_s  = mul_early_s ? (mul_step_s >> cnt_q) : mul_step_s;
`else
    mul_early_s = 1'b0;
    mul_next_s  = mul_step_s;
`endif
    // Remainder stays below the divisor, so the borrow bit of diff is a clean compare.
    rem_sh_s  = {rem_q, acc_q[XLEN-1]};
    diff_s    = rem_sh_s - {2'b00, mcand_q};
    qbit_s    = ~diff_s[XLEN+1];
    div_rem_s = qbit_s ? diff_s[XLEN:0] : rem_sh_s[XLEN:0];
    div_acc_s = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], qbit_s};

    prod_s = neg_res_q ? -acc_q : acc_q;
    quot_s = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    remv_s = neg_rem_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
    if (is_div(op_q)) begin
      fix_res_s = is_rem(op_q) ? remv_s : quot_s;
    end else begin
      fix_res_s = wants_high(op_q) ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
    end
  end

  // Next-state and output decode for the IDLE/CALC/FIX/DONE sequence.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    rem_d       = rem_q;
    mcand_d     = mcand_q;
    op_d        = op_q;
    neg_res_d   = neg_res_q;
    neg_rem_d   = neg_rem_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            op_d      = op_in_s;
            neg_res_d = neg_result_s;
            neg_rem_d = neg_rem_s;
            cnt_d     = CNT_W'(XLEN-1);
            rem_d     = {(XLEN+1){1'b0}};
            if (is_div(op_in_s)) begin
              acc_d   = {{XLEN{1'b0}}, abs_a_s};
              mcand_d = abs_b_s;
            end else begin
              acc_d   = {{XLEN{1'b0}}, abs_b_s};
              mcand_d = abs_a_s;
            end
            if (div_by_zero_s) begin
              state_d     = ST_DONE;
              out_valid_d = 1'b1;
              result_d    = is_rem(op_in_s) ? a : {XLEN{1'b1}};
            end else if (overflow_s) begin
              state_d     = ST_DONE;
              out_valid_d = 1'b1;
              result_d    = is_rem(op_in_s) ? {XLEN{1'b0}} : MIN_INT;
            end else begin
              state_d = ST_CALC;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_CALC: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (is_div(op_q)) begin
            acc_d = div_acc_s;
            rem_d = div_rem_s;
          end else begin
            acc_d = mul_next_s;
          end
          if ((cnt_q == {CNT_W{1'b0}}) || (!is_div(op_q) && mul_early_s)) begin
            state_d = ST_FIX;
          end else begin
            state_d = ST_CALC;
          end
        end
        ST_FIX: begin
          result_d    = fix_res_s;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      endcase
    end
    in_ready_d = (state_d == ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      acc_q       <= {(2*XLEN){1'b0}};
      rem_q       <= {(XLEN+1){1'b0}};
      mcand_q     <= {XLEN{1'b0}};
      op_q        <= OP_MUL;
      neg_res_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      result_q    <= {XLEN{1'b0}};
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      mcand_q     <= mcand_d;
      op_q        <= op_d;
      neg_res_q   <= neg_res_d;
      neg_rem_q   <= neg_rem_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign busy      = busy_q;

endmodule
